alu_issue: RTL and testbench



---
 rtl/luna_pkg.sv | 41 ++++
 rtl/alu_regfile.sv | 35 +++
 rtl/alu_issue.sv | 168 ++++++++++++++++
 tb/tb_alu_issue.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/luna_pkg.sv
// Shared definitions for the decode-and-issue stage: widths, instruction
// class encodings, instruction field positions and the FSM state type.
package luna_pkg;

    localparam int DATA_W     = 16;
    localparam int REG_ADDR_W = 3;
    localparam int NUM_REGS   = 1 << REG_ADDR_W;
    localparam int IMM_W      = 11;

    typedef enum logic [1:0] {
        CLS_ALU = 2'b00,
        CLS_LDI = 2'b01,
        CLS_CMP = 2'b10,
        CLS_ILL = 2'b11
    } instr_class_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EXEC,
        ST_DONE
    } state_e;

    localparam int CLS_HI    = 15;
    localparam int CLS_LO    = 14;
    localparam int OP_HI     = 13;
    localparam int OP_LO     = 12;
    localparam int ZX_BIT    = 11;
    localparam int ZY_BIT    = 10;
    localparam int NEG_BIT   = 9;
    localparam int RD_HI     = 8;
    localparam int RD_LO     = 6;
    localparam int RSX_HI    = 5;
    localparam int RSX_LO    = 3;
    localparam int RSY_HI    = 2;
    localparam int RSY_LO    = 0;
    localparam int LDI_RD_HI = 13;
    localparam int LDI_RD_LO = 11;
    localparam int IMM_HI    = 10;
    localparam int IMM_LO    = 0;

endpackage

// File: rtl/alu_regfile.sv
// 8x16 general-purpose register file: two operand read ports, one debug
// read port, one synchronous write port, cleared asynchronously on reset.
module alu_regfile
    import luna_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_we,
    input  logic [REG_ADDR_W-1:0] i_waddr,
    input  logic [DATA_W-1:0]     i_wdata,
    input  logic [REG_ADDR_W-1:0] i_raddr_x,
    input  logic [REG_ADDR_W-1:0] i_raddr_y,
    input  logic [REG_ADDR_W-1:0] i_dbg_addr,
    output logic [DATA_W-1:0]     o_rdata_x,
    output logic [DATA_W-1:0]     o_rdata_y,
    output logic [DATA_W-1:0]     o_dbg_data
);

    logic [DATA_W-1:0] r_mem [NUM_REGS];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata_x  = r_mem[i_raddr_x];
    assign o_rdata_y  = r_mem[i_raddr_y];
    assign o_dbg_data = r_mem[i_dbg_addr];

endmodule

// File: rtl/alu_issue.sv
// Decode-and-issue stage in front of the ALU: accepts one instruction at a
// time, drives ALU operands/controls, waits out the ALU latency, writes back.
module alu_issue
    import luna_pkg::*;
#(
    parameter int ALU_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  instr_valid,
    output logic                  instr_ready,
    input  logic [DATA_W-1:0]     instr,
    output logic [DATA_W-1:0]     alu_x,
    output logic [DATA_W-1:0]     alu_y,
    output logic                  alu_zero_x,
    output logic                  alu_zero_y,
    output logic                  alu_negate_output,
    output logic [1:0]            alu_opcode,
    input  logic [DATA_W-1:0]     alu_result,
    input  logic                  alu_is_zero,
    input  logic                  alu_is_negative,
    output logic                  flag_zero,
    output logic                  flag_negative,
    output logic                  done,
    output logic                  illegal,
    input  logic [REG_ADDR_W-1:0] dbg_addr,
    output logic [DATA_W-1:0]     dbg_data
);

    localparam logic [1:0] LAT_CNT = 2'(ALU_LATENCY);

    state_e                r_state;
    state_e                w_next_state;
    logic                  r_live;
    logic [1:0]            r_cnt;
    logic [REG_ADDR_W-1:0] r_rd;
    logic                  r_wb;
    logic [DATA_W-1:0]     r_alu_x;
    logic [DATA_W-1:0]     r_alu_y;
    logic                  r_zx;
    logic                  r_zy;
    logic                  r_neg;
    logic [1:0]            r_op;
    logic                  r_flag_z;
    logic                  r_flag_n;
    logic                  r_illegal;

    instr_class_e          w_class;
    logic                  w_accept;
    logic                  w_issue;
    logic                  w_exec_last;
    logic [DATA_W-1:0]     w_rdata_x;
    logic [DATA_W-1:0]     w_rdata_y;
    logic                  w_we;
    logic [REG_ADDR_W-1:0] w_waddr;
    logic [DATA_W-1:0]     w_wdata;

    assign w_class     = instr_class_e'(instr[CLS_HI:CLS_LO]);
    assign w_accept    = instr_valid && instr_ready;
    assign w_issue     = w_accept && (w_class == CLS_ALU || w_class == CLS_CMP);
    assign w_exec_last = (r_state == ST_EXEC) && (r_cnt == 2'd0);

    // LDI writes on its accepting edge; ALU writes on the last EXEC edge.
    // The two never coincide because accepts only happen in IDLE.
    assign w_we    = (w_accept && w_class == CLS_LDI) || (w_exec_last && r_wb);
    assign w_waddr = w_exec_last ? r_rd : instr[LDI_RD_HI:LDI_RD_LO];
    assign w_wdata = w_exec_last ? alu_result
                                 : {{(DATA_W-IMM_W){1'b0}}, instr[IMM_HI:IMM_LO]};

    alu_regfile u_regfile (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_we       (w_we),
        .i_waddr    (w_waddr),
        .i_wdata    (w_wdata),
        .i_raddr_x  (instr[RSX_HI:RSX_LO]),
        .i_raddr_y  (instr[RSY_HI:RSY_LO]),
        .i_dbg_addr (dbg_addr),
        .o_rdata_x  (w_rdata_x),
        .o_rdata_y  (w_rdata_y),
        .o_dbg_data (dbg_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_issue) begin
                    w_next_state = ST_EXEC;
                end else if (w_accept && w_class == CLS_LDI) begin
                    w_next_state = ST_DONE;
                end
            end
            ST_EXEC: begin
                if (r_cnt == 2'd0) begin
                    w_next_state = ST_DONE;
                end
            end
            ST_DONE: w_next_state = ST_IDLE;
            default: w_next_state = ST_IDLE;
        endcase
    end

    // r_live holds ready low until the first edge after reset release.
    always_comb begin
        instr_ready = (r_state == ST_IDLE) && r_live;
        done        = (r_state == ST_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_live    <= 1'b0;
            r_cnt     <= '0;
            r_rd      <= '0;
            r_wb      <= 1'b0;
            r_alu_x   <= '0;
            r_alu_y   <= '0;
            r_zx      <= 1'b0;
            r_zy      <= 1'b0;
            r_neg     <= 1'b0;
            r_op      <= '0;
            r_flag_z  <= 1'b0;
            r_flag_n  <= 1'b0;
            r_illegal <= 1'b0;
        end else begin
            r_live    <= 1'b1;
            r_illegal <= w_accept && (w_class == CLS_ILL);
            if (w_issue) begin
                r_alu_x <= w_rdata_x;
                r_alu_y <= w_rdata_y;
                r_op    <= instr[OP_HI:OP_LO];
                r_zx    <= instr[ZX_BIT];
                r_zy    <= instr[ZY_BIT];
                r_neg   <= instr[NEG_BIT];
                r_rd    <= instr[RD_HI:RD_LO];
                r_wb    <= (w_class == CLS_ALU);
                r_cnt   <= LAT_CNT;
            end
            if (r_state == ST_EXEC) begin
                if (r_cnt != 2'd0) begin
                    r_cnt <= r_cnt - 2'd1;
                end else begin
                    r_flag_z <= alu_is_zero;
                    r_flag_n <= alu_is_negative;
                end
            end
        end
    end

    assign alu_x             = r_alu_x;
    assign alu_y             = r_alu_y;
    assign alu_zero_x        = r_zx;
    assign alu_zero_y        = r_zy;
    assign alu_negate_output = r_neg;
    assign alu_opcode        = r_op;
    assign flag_zero         = r_flag_z;
    assign flag_negative     = r_flag_n;
    assign illegal           = r_illegal;

endmodule

// File: tb/tb_alu_issue.sv
// Self-checking bench for alu_issue: directed scenarios plus random
// instructions compared against an architectural register/flag model.
`timescale 1ns/1ps
module tb_alu_issue;

    localparam int LAT = 1;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        instr_valid = 1'b0;
    logic        instr_ready;
    logic [15:0] instr = '0;
    logic [15:0] alu_x;
    logic [15:0] alu_y;
    logic        alu_zero_x;
    logic        alu_zero_y;
    logic        alu_negate_output;
    logic [1:0]  alu_opcode;
    logic [15:0] alu_result;
    logic        alu_is_zero;
    logic        alu_is_negative;
    logic        flag_zero;
    logic        flag_negative;
    logic        done;
    logic        illegal;
    logic [2:0]  dbg_addr = '0;
    logic [15:0] dbg_data;

    logic [15:0] modelReg [8];
    logic        modelZ;
    logic        modelN;
    logic [15:0] aluPipe = '0;
    int          numChecks = 0;
    int          numPassed = 0;

    always #5 clk = ~clk;

    alu_issue #(.ALU_LATENCY(LAT)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .instr_valid       (instr_valid),
        .instr_ready       (instr_ready),
        .instr             (instr),
        .alu_x             (alu_x),
        .alu_y             (alu_y),
        .alu_zero_x        (alu_zero_x),
        .alu_zero_y        (alu_zero_y),
        .alu_negate_output (alu_negate_output),
        .alu_opcode        (alu_opcode),
        .alu_result        (alu_result),
        .alu_is_zero       (alu_is_zero),
        .alu_is_negative   (alu_is_negative),
        .flag_zero         (flag_zero),
        .flag_negative     (flag_negative),
        .done              (done),
        .illegal           (illegal),
        .dbg_addr          (dbg_addr),
        .dbg_data          (dbg_data)
    );

    function automatic logic [15:0] aluFunc(input logic [1:0] op, input logic zx, input logic zy,
                                            input logic ng, input logic [15:0] x, input logic [15:0] y);
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] r;
        a = zx ? 16'h0 : x;
        b = zy ? 16'h0 : y;
        case (op)
            2'd0:    r = a & b;
            2'd1:    r = a | b;
            2'd2:    r = a + b;
            default: r = a - b;
        endcase
        return ng ? ~r : r;
    endfunction

    // Behavioural ALU with a single pipeline stage (LAT = 1).
    always @(posedge clk) begin
        aluPipe <= aluFunc(alu_opcode, alu_zero_x, alu_zero_y, alu_negate_output, alu_x, alu_y);
    end
    assign alu_result      = aluPipe;
    assign alu_is_zero     = (aluPipe == 16'h0);
    assign alu_is_negative = aluPipe[15];

    function automatic logic [15:0] mkOp(input logic [1:0] cls, input logic [1:0] op, input logic zx,
                                         input logic zy, input logic ng, input logic [2:0] rd,
                                         input logic [2:0] rx, input logic [2:0] ry);
        return {cls, op, zx, zy, ng, rd, rx, ry};
    endfunction

    function automatic logic [15:0] mkLdi(input logic [2:0] rd, input logic [10:0] imm);
        return {2'b01, rd, imm};
    endfunction

    task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
        numChecks++;
        if (observed === expected) begin
            numPassed++;
        end else begin
            $display("[TB] FAIL %s: observed %h, expected %h", tag, observed, expected);
        end
    endtask

    task automatic readReg(input logic [2:0] a, output logic [15:0] d);
        dbg_addr = a;
        #0.2;
        d = dbg_data;
    endtask

    task automatic checkRegs(input string tag);
        logic [15:0] d;
        for (int i = 0; i < 8; i++) begin
            readReg(3'(i), d);
            checkOutput($sformatf("%s_r%0d", tag, i), d, modelReg[i]);
        end
    endtask

    task automatic checkFlags(input string tag);
        checkOutput(tag, 16'({flag_zero, flag_negative}), 16'({modelZ, modelN}));
    endtask

    task automatic applyStimulus(input logic [15:0] w);
        logic [1:0]  cls;
        logic [2:0]  rd;
        logic [2:0]  ldRd;
        logic [15:0] expX;
        logic [15:0] expY;
        logic [15:0] res;
        logic [15:0] d;
        int          cyc;
        cls  = w[15:14];
        rd   = w[8:6];
        ldRd = w[13:11];
        @(negedge clk);
        checkOutput("readyBefore", 16'(instr_ready), 16'h1);
        instr_valid = 1'b1;
        instr       = w;
        @(negedge clk);
        instr_valid = 1'b0;
        cyc = 1;
        case (cls)
            2'b11: begin
                checkOutput("illegalPulse", 16'(illegal), 16'h1);
                checkOutput("illegalReady", 16'(instr_ready), 16'h1);
                checkOutput("illegalNoDone", 16'(done), 16'h0);
                @(negedge clk);
                checkOutput("illegalOnce", 16'(illegal), 16'h0);
                checkFlags("illegalFlags");
            end
            2'b01: begin
                modelReg[ldRd] = {5'b0, w[10:0]};
                checkOutput("ldiDone", 16'(done), 16'h1);
                readReg(ldRd, d);
                checkOutput("ldiVisible", d, modelReg[ldRd]);
                @(negedge clk);
                checkOutput("ldiDoneLow", 16'(done), 16'h0);
                checkOutput("ldiReadyAgain", 16'(instr_ready), 16'h1);
                checkFlags("ldiFlags");
            end
            default: begin
                expX = modelReg[w[5:3]];
                expY = modelReg[w[2:0]];
                res  = aluFunc(w[13:12], w[11], w[10], w[9], expX, expY);
                while (done !== 1'b1 && cyc < 20) begin
                    checkOutput("aluX", alu_x, expX);
                    checkOutput("aluY", alu_y, expY);
                    checkOutput("aluCtrl", 16'({alu_opcode, alu_zero_x, alu_zero_y, alu_negate_output}),
                                16'({w[13:12], w[11], w[10], w[9]}));
                    checkOutput("busyReady", 16'(instr_ready), 16'h0);
                    @(negedge clk);
                    cyc++;
                end
                checkOutput("doneCycle", 16'(cyc), 16'(LAT + 2));
                if (cls == 2'b00) begin
                    modelReg[rd] = res;
                end
                modelZ = (res == 16'h0);
                modelN = res[15];
                checkFlags("execFlags");
                @(negedge clk);
                checkOutput("execDoneLow", 16'(done), 16'h0);
                checkOutput("execReadyAgain", 16'(instr_ready), 16'h1);
            end
        endcase
        checkRegs("regs");
    endtask

    initial begin
        logic [15:0] w;
        logic [15:0] d;
        logic [15:0] res;
        int          cyc;
        for (int i = 0; i < 8; i++) modelReg[i] = '0;
        modelZ = 1'b0;
        modelN = 1'b0;

        #12 rst_n = 1'b1;
        @(negedge clk);
        checkOutput("resetReady", 16'(instr_ready), 16'h1);
        checkFlags("resetFlags");
        checkOutput("resetDone", 16'(done), 16'h0);
        checkOutput("resetAluX", alu_x, 16'h0);
        checkRegs("reset");

        applyStimulus(mkLdi(3'd1, 11'h002));
        applyStimulus(mkLdi(3'd2, 11'h005));
        applyStimulus(mkOp(2'b00, 2'd2, 1'b0, 1'b0, 1'b0, 3'd3, 3'd1, 3'd2));
        applyStimulus(mkOp(2'b10, 2'd2, 1'b1, 1'b1, 1'b0, 3'd5, 3'd1, 3'd2));
        checkOutput("cmpZero", 16'(flag_zero), 16'h1);

        // Illegal followed immediately by an LDI in the next cycle
        @(negedge clk);
        instr_valid = 1'b1;
        instr       = 16'hC000;
        @(negedge clk);
        checkOutput("illPulse", 16'(illegal), 16'h1);
        checkOutput("illReadyB2B", 16'(instr_ready), 16'h1);
        instr = mkLdi(3'd7, 11'h3AB);
        @(negedge clk);
        instr_valid = 1'b0;
        modelReg[7] = 16'h03AB;
        checkOutput("b2bLdiDone", 16'(done), 16'h1);
        checkOutput("illOnce", 16'(illegal), 16'h0);
        checkFlags("illFlags");
        @(negedge clk);
        checkRegs("illB2B");

        // LDI held valid while an ALU instruction is in flight
        w = mkOp(2'b00, 2'd2, 1'b0, 1'b0, 1'b0, 3'd6, 3'd1, 3'd2);
        res = aluFunc(2'd2, 1'b0, 1'b0, 1'b0, modelReg[1], modelReg[2]);
        @(negedge clk);
        instr_valid = 1'b1;
        instr       = w;
        @(negedge clk);
        instr = mkLdi(3'd5, 11'h123);
        cyc = 1;
        while (done !== 1'b1 && cyc < 20) begin
            readReg(3'd5, d);
            checkOutput("heldNotAccepted", d, modelReg[5]);
            @(negedge clk);
            cyc++;
        end
        checkOutput("heldDoneCycle", 16'(cyc), 16'(LAT + 2));
        modelReg[6] = res;
        modelZ = (res == 16'h0);
        modelN = res[15];
        @(negedge clk);
        checkOutput("heldReadyIdle", 16'(instr_ready), 16'h1);
        @(negedge clk);
        instr_valid = 1'b0;
        modelReg[5] = 16'h0123;
        checkOutput("heldLdiDone", 16'(done), 16'h1);
        @(negedge clk);
        checkFlags("heldFlags");
        checkRegs("held");

        // Reset asserted while in EXEC
        w = mkOp(2'b00, 2'd2, 1'b1, 1'b0, 1'b1, 3'd4, 3'd1, 3'd2);
        @(negedge clk);
        instr_valid = 1'b1;
        instr       = w;
        @(negedge clk);
        checkOutput("midExecX", alu_x, modelReg[1]);
        checkOutput("midExecBusy", 16'(instr_ready), 16'h0);
        #1 rst_n = 1'b0;
        #1;
        for (int i = 0; i < 8; i++) modelReg[i] = '0;
        modelZ = 1'b0;
        modelN = 1'b0;
        checkOutput("abortAluX", alu_x, 16'h0);
        checkOutput("abortAluY", alu_y, 16'h0);
        checkOutput("abortCtrl", 16'({alu_opcode, alu_zero_x, alu_zero_y, alu_negate_output}), 16'h0);
        checkOutput("abortDone", 16'(done), 16'h0);
        checkOutput("abortIllegal", 16'(illegal), 16'h0);
        checkFlags("abortFlags");
        @(negedge clk);
        instr_valid = 1'b0;
        rst_n       = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checkOutput("noDoneAfterAbort", 16'(done), 16'h0);
        end
        checkOutput("abortReady", 16'(instr_ready), 16'h1);
        checkRegs("abort");

        for (int n = 0; n < 40; n++) begin
            logic [1:0] cls;
            cls = 2'($urandom_range(0, 3));
            if (cls == 2'b01) begin
                w = mkLdi(3'($urandom), 11'($urandom));
            end else if (cls == 2'b11) begin
                w = {2'b11, 14'($urandom)};
            end else begin
                w = mkOp(cls, 2'($urandom), 1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 3) == 0),
                         1'($urandom), 3'($urandom), 3'($urandom), 3'($urandom));
            end
            applyStimulus(w);
        end

        $display("%0d/%0d checks passed", numPassed, numChecks);
        $finish;
    end

endmodule
